// File: rtl/freq_meter_gate.sv
// Gated frequency meter: counts synchronised sig_in rising edges between tick_1s gates,
// latches the window count and converts it to packed BCD with a bit-serial double-dabble.

module fmg_dabble_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module freq_meter_gate #(
  parameter int CNT_W  = 26,
  parameter int DIGITS = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick_1s,
  input  logic                sig_in,
  output logic [CNT_W-1:0]    freq_bin,
  output logic [4*DIGITS-1:0] freq_bcd,
  output logic                overflow,
  output logic                valid,
  output logic                busy
);

  localparam int SC_W = $clog2(CNT_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic                s1, s2, sprev;
  logic                rise, latch;
  logic [CNT_W-1:0]    cnt;
  logic                ovf, primed;
  logic [CNT_W-1:0]    sh;
  logic [4*DIGITS-1:0] scr, scr_adj, scr_nxt;
  logic [SC_W-1:0]     nshift;
  state_t              state;

  assign rise  = s2 & ~sprev;
  assign latch = tick_1s & primed;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    fmg_dabble_digit u_dig (.d(scr[4*i +: 4]), .q(scr_adj[4*i +: 4]));
  end

  assign scr_nxt = (4*DIGITS)'({scr_adj, sh[CNT_W-1]});

  always_ff @(posedge clock) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      sprev    <= 1'b0;
      cnt      <= '0;
      ovf      <= 1'b0;
      primed   <= 1'b0;
      sh       <= '0;
      scr      <= '0;
      nshift   <= '0;
      state    <= IDLE;
      freq_bin <= '0;
      freq_bcd <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      s1    <= sig_in;
      s2    <= s1;
      sprev <= s2;
      valid <= 1'b0;

      // An edge seen in the gate cycle opens the new window rather than closing the old one.
      if (tick_1s) begin
        cnt    <= rise ? CNT_W'(1) : '0;
        ovf    <= 1'b0;
        primed <= 1'b1;
      end else if (rise) begin
        if (cnt == CNT_MAX) ovf <= 1'b1;
        else                cnt <= cnt + CNT_W'(1);
      end

      // A gate always wins over an in-flight conversion, so an aborted result never emits valid.
      if (latch) begin
        freq_bin <= cnt;
        overflow <= ovf;
        sh       <= cnt;
        scr      <= '0;
        nshift   <= '0;
        state    <= SHIFT;
        busy     <= 1'b1;
      end else begin
        case (state)
          IDLE: busy <= 1'b0;
          SHIFT: begin
            scr    <= scr_nxt;
            sh     <= sh << 1;
            nshift <= nshift + SC_W'(1);
            // Final shift publishes directly so the DONE cycle is the valid cycle.
            if (nshift == SC_W'(CNT_W - 1)) begin
              freq_bcd <= scr_nxt;
              valid    <= 1'b1;
              busy     <= 1'b0;
              state    <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_meter_gate.sv
// Scoreboard bench for freq_meter_gate: a default instance and a narrow (CNT_W=4) one share stimulus;
// expected window results come from counting edges per gate with plain integer arithmetic.

module tb_freq_meter_gate;

  logic clock = 1'b0;
  logic reset = 1'b1, tick_1s = 1'b0, sig_in = 1'b0;
  always #10 clock = ~clock;

  logic [25:0] fb0;  logic [31:0] bcd0;  logic ovf0, v0, busy0;
  logic [3:0]  fb1;  logic [7:0]  bcd1;  logic ovf1, v1, busy1;

  freq_meter_gate u_big (
    .clock(clock), .reset(reset), .tick_1s(tick_1s), .sig_in(sig_in),
    .freq_bin(fb0), .freq_bcd(bcd0), .overflow(ovf0), .valid(v0), .busy(busy0));

  freq_meter_gate #(.CNT_W(4), .DIGITS(2)) u_small (
    .clock(clock), .reset(reset), .tick_1s(tick_1s), .sig_in(sig_in),
    .freq_bin(fb1), .freq_bcd(bcd1), .overflow(ovf1), .valid(v1), .busy(busy1));

  typedef struct {
    int          due;
    logic [31:0] bin;
    logic [31:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t q0[$], q1[$];
  int   tests = 0, fails = 0;
  int   cyc = 0;
  bit   go = 0;
  bit   sig_h [0:32799];
  bit   rst_h [0:32799];
  bit   bh0   [0:32799];
  bit   bh1   [0:32799];
  int   n_edges = 0;
  bit   primed_m = 0;
  bit   hold_v = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r = '0;
    for (int d = 0; d < 8; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic exp_t mk_exp(input int n, input int maxv, input int due);
    exp_t e;
    e.due = due;
    e.ovf = (n > maxv);
    e.bin = (n > maxv) ? maxv : n;
    e.bcd = to_bcd(int'(e.bin));
    return e;
  endfunction

  task automatic drop_after(input int k);
    while (q0.size() > 0 && q0[$].due > k) void'(q0.pop_back());
    while (q1.size() > 0 && q1[$].due > k) void'(q1.pop_back());
  endtask

  // Called on a falling edge; inputs belong to cycle k = cyc.
  task automatic drive(input bit s, input bit t, input bit r);
    int  k = cyc;
    bit  e;
    sig_in  = s;
    tick_1s = t;
    reset   = r;
    sig_h[k] = r ? 1'b0 : s;
    rst_h[k] = r;
    if (r) begin
      primed_m = 0;
      n_edges  = 0;
      drop_after(k);
      for (int c = k + 1; c <= k + 30; c++) begin bh0[c] = 0; bh1[c] = 0; end
    end else begin
      // A level change is seen as an edge two cycles later; reset clears the synchroniser.
      e = (k >= 3) && !rst_h[k-1] && sig_h[k-2] && !sig_h[k-3];
      if (t) begin
        if (primed_m) begin
          drop_after(k);
          q0.push_back(mk_exp(n_edges, (1 << 26) - 1, k + 27));
          q1.push_back(mk_exp(n_edges, 15, k + 5));
          for (int c = k + 1; c <= k + 26; c++) bh0[c] = 1;
          for (int c = k + 1; c <= k + 4; c++)  bh1[c] = 1;
        end
        n_edges  = e ? 1 : 0;
        primed_m = 1;
      end else if (e) begin
        n_edges++;
      end
    end
    @(negedge clock);
  endtask

  task automatic run(input int len, input int half, input int act);
    bit s;
    for (int i = 0; i < len; i++) begin
      s = (half > 0 && i < act) ? ((i / half) % 2 == 1) : hold_v;
      drive(s, i == len - 1, 1'b0);
    end
  endtask

  task automatic run_coinc(input int len);
    for (int i = 0; i < len; i++) drive(i >= len - 3, i == len - 1, 1'b0);
  endtask

  task automatic run_rnd(input int len);
    for (int i = 0; i < len; i++) drive(1'($urandom_range(0, 1)), i == len - 1, 1'b0);
  endtask

  task automatic check(input int d, input logic v, input logic [31:0] bin, input logic [31:0] bcd,
                       input logic ovf, input logic b, input bit bexp);
    exp_t e;
    int   qs;
    tests++;
    if (b !== bexp) begin
      fails++;
      $display("FAIL busy dut%0d cyc %0d: got %b want %b", d, cyc, b, bexp);
    end
    if (cyc > 0 && rst_h[cyc-1]) begin
      tests++;
      if (v !== 1'b0 || bin !== 32'd0 || bcd !== 32'd0 || ovf !== 1'b0 || b !== 1'b0) begin
        fails++;
        $display("FAIL reset_state dut%0d cyc %0d: got v=%b bin=%h bcd=%h ovf=%b busy=%b want all 0",
                 d, cyc, v, bin, bcd, ovf, b);
      end
    end
    qs = (d == 0) ? q0.size() : q1.size();
    if (v === 1'b1) begin
      tests++;
      if (qs == 0) begin
        fails++;
        $display("FAIL unexpected_valid dut%0d cyc %0d: got bin=%0d bcd=%h want no valid", d, cyc, bin, bcd);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        if (e.due != cyc || bin !== e.bin || bcd !== e.bcd || ovf !== e.ovf) begin
          fails++;
          $display("FAIL result dut%0d cyc %0d: got bin=%0d bcd=%h ovf=%b want bin=%0d bcd=%h ovf=%b at cyc %0d",
                   d, cyc, bin, bcd, ovf, e.bin, e.bcd, e.ovf, e.due);
        end
      end
    end else if (qs > 0) begin
      e = (d == 0) ? q0[0] : q1[0];
      if (e.due < cyc) begin
        tests++;
        fails++;
        $display("FAIL missing_valid dut%0d cyc %0d: got none want bin=%0d at cyc %0d", d, cyc, e.bin, e.due);
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
  endtask

  always @(negedge clock) begin
    if (go) begin
      check(0, v0, 32'(fb0), bcd0, ovf0, busy0, bh0[cyc]);
      check(1, v1, 32'(fb1), 32'(bcd1), ovf1, busy1, bh1[cyc]);
    end
  end

  initial begin
    @(negedge clock);
    drive(0, 0, 1);
    go = 1;
    drive(0, 0, 1);
    drive(0, 0, 1);
    for (int i = 0; i < 5; i++) drive(0, 0, 0);

    // toggle every 5 clocks, 200-clock windows: 20 Hz, first gate discarded
    repeat (4) run(200, 5, 200);
    // toggle every clock: 100 edges (narrow instance saturates)
    repeat (2) run(200, 1, 200);
    // held high: no edges
    hold_v = 1;
    repeat (2) run(200, 0, 0);
    hold_v = 0;
    // a short burst of 3 edges
    run(60, 5, 30);
    run(60, 5, 30);
    // edge landing exactly in the gate cycle belongs to the next window
    run(100, 5, 70);
    run_coinc(50);
    run(100, 5, 50);
    // gate during conversion: only the second result survives
    run(200, 5, 200);
    run(10, 5, 10);
    run(200, 5, 200);
    // reset in the middle of a conversion
    run(200, 5, 200);
    for (int i = 0; i < 10; i++) drive(i[0], 0, 0);
    drive(0, 0, 1);
    drive(0, 0, 1);
    run(200, 5, 200);
    run(200, 1, 200);
    run(200, 5, 200);

    // randomized windows, spacing and occasional resets
    for (int w = 0; w < 60; w++) begin
      if ($urandom_range(0, 9) == 0)
        repeat ($urandom_range(1, 3)) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      run_rnd($urandom_range(3, 120));
    end

    for (int i = 0; i < 40; i++) drive(0, 0, 0);
    tests++;
    if (q0.size() != 0) begin
      fails++;
      $display("FAIL drain dut0: got %0d pending want 0", q0.size());
    end
    tests++;
    if (q1.size() != 0) begin
      fails++;
      $display("FAIL drain dut1: got %0d pending want 0", q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/freq_meter_gate.md
Name: freq_meter_gate

Overview:
- Downstream consumer of the 1 s timebase tick. Uses each `tick_1s` pulse as a one-second gate window.
- Counts rising edges of an external asynchronous signal during the window and latches the count at the end of the window, giving frequency in Hz.
- Converts the latched count to packed BCD for the display/instrumentation stage.
- Sits between the seconds timebase and the 7-segment/display driver.

Parameters:
- CNT_W, 26, width of the edge counter and of `freq_bin`. Default covers 50 MHz / 2 = 25,000,000 edges/s.
- DIGITS, 8, number of BCD digits on `freq_bcd`. Must satisfy 10^DIGITS > 2^CNT_W-1.

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- tick_1s  in  1  one-cycle pulse marking the end/start of a gate window; synchronous to `clock`
- sig_in  in  1  external signal under measurement; asynchronous
- freq_bin  out  CNT_W  last complete window's edge count, binary
- freq_bcd  out  4*DIGITS  `freq_bin` in packed BCD; digit 0 in bits [3:0]
- overflow  out  1  last complete window saturated
- valid  out  1  one-cycle pulse when `freq_bcd`/`freq_bin`/`overflow` form a new consistent result
- busy  out  1  BCD conversion in progress

Behaviour:
- **Clocking and reset.** Single clock domain, `clock`. Reset is synchronous and active-high. On reset:
  - `freq_bin`=0, `freq_bcd`=0, `overflow`=0, `valid`=0, `busy`=0.
  - Counter=0, synchroniser flops=0, `primed`=0, FSM=IDLE.
- **Input conditioning.**
  - `sig_in` passes through a 2-flop synchroniser, then a third flop holds the previous value.
  - Rising edge = sync2 & ~prev.
  - A `sig_in` rise is counted 3 clocks later.
  - Pulses narrower than one clock period are not guaranteed to be counted.
- **Edge counter.**
  - Increments on each detected edge.
  - At 2^CNT_W-1, further edges hold the value (saturate) and set the internal `ovf` flag for the current window.
- **Gate (cycle T where `tick_1s`=1).**
  - Counter reloads to 1 if an edge is detected in cycle T, else 0; `ovf` is cleared likewise. An edge coincident with the tick belongs to the new window.
  - If `primed`=0: set `primed`=1 and produce no result. The first window after reset is partial and is discarded.
  - If `primed`=1: at T+1, `freq_bin` holds the pre-tick counter value and `overflow` holds the pre-tick `ovf`; start BCD conversion.
- **BCD FSM** (double-dabble, one bit per clock):
  - IDLE: `busy`=0. On latch, load the shift register with `freq_bin` and clear the BCD scratch, then go to SHIFT.
  - SHIFT: `busy`=1. Each cycle, add 3 to every scratch digit >= 5, then shift left one bit. After exactly CNT_W shifts, go to DONE.
  - DONE: write scratch to `freq_bcd`, assert `valid` for one cycle, return to IDLE.
  - Timing: `valid` is high in cycle T+CNT_W+1 (27 cycles after the tick cycle at default).
  - `freq_bcd` changes only in the `valid` cycle. Between T+1 and the `valid` cycle, `freq_bin`/`overflow` may lead `freq_bcd`; consumers sample on `valid`.
- **Boundary conditions.**
  - Tick during SHIFT: new value latched into `freq_bin`/`overflow`; conversion restarts from the new value; the aborted conversion produces no `valid`.
  - `valid` never pulses twice for one window.
  - Reset mid-window or mid-conversion: all state returns to reset values, no `valid` is issued, and the next tick is again discarded.
  - `tick_1s` held high for several cycles: each high cycle is a gate. Not a supported use; behaviour stays as defined per cycle.

Test Plan:
1. Reset, then `tick_1s` every 200 clocks, `sig_in` toggling every 5 clocks → first tick gives no `valid`. Each later tick gives `freq_bin`=20, `freq_bcd`=0x00000020, `overflow`=0, `valid` exactly 27 cycles after the tick, `busy` high for 26 cycles.
2. `sig_in` toggling every clock, tick every 200 clocks → `freq_bin`=100, `freq_bcd`=0x00000100. With `sig_in` held at 1 → `freq_bin`=0.
3. CNT_W=4, DIGITS=2, 20 edges in one window → `freq_bin`=15, `overflow`=1, `freq_bcd`=0x15. Next window with 3 edges → `freq_bin`=3, `overflow`=0.
4. Synchronised edge landing exactly in the tick cycle → excluded from the closing window (e.g. 7 not 8), included in the next window's count.
5. Ticks 10 clocks apart (inside conversion) → only the second window produces `valid`, with its own value; no stale BCD.
6. Assert `reset` at T+10 during SHIFT → all outputs 0, no `valid`. The next tick is discarded; the following tick produces a correct result.
